donkey_move_ctl: RTL
====================

Name: donkey_move_ctl

Overview:
Player-side position controller for Donkey. It converts left/right/jump button levels into the sprite position (xpos, ypos) using the character package constants. Its outputs are the position inputs of the Donkey sprite draw block and the collision logic. Kong's motion is scripted elsewhere; this block is the player-driven counterpart to that motion.

Parameters:
MOVE_CYCLES, 250_000, clock cycles per horizontal 1-pixel step (MOVE_TAKI_NIE_MACQUEEN)
JUMP_CYCLES, 1_400_000, clock cycles per vertical 1-pixel jump step (JUMP_TAKI_W_MIARE)
JUMP_HEIGHT, 58, pixels risen per full jump (DONKEY_JUMP_HEIGHT)
INIT_XPOS, 128, xpos after reset (DONKEY_INITIAL_XPOS)
GROUND_YPOS, 672, ypos at rest and after reset (DONKEY_INITIAL_YPOS)
X_MIN, 0, leftmost legal xpos
X_MAX, 976, rightmost legal xpos (1024 - CHARACTER_WIDTH)

Ports:
clk  in  1  system clock
rst  in  1  reset; asynchronous, active-high
left  in  1  left button level, synchronous to clk
right  in  1  right button level, synchronous to clk
jump  in  1  jump button level, synchronous to clk
xpos  out  12  Donkey sprite left edge, pixels
ypos  out  12  Donkey sprite top edge, pixels
airborne  out  1  high while the jump FSM is in RISE or FALL
face_left  out  1  last horizontal direction moved: 1 = left, 0 = right

Behaviour:
- Reset (async, rst=1) values: xpos=INIT_XPOS, ypos=GROUND_YPOS, airborne=0, face_left=0, FSM=IDLE, both tick counters=0, jump edge register=0.
- All outputs are registered.
- Move tick:
  - move_cnt counts 0..MOVE_CYCLES-1 and wraps; move_tick=1 on the cycle move_cnt==MOVE_CYCLES-1.
  - The counter free-runs in every FSM state.
- Horizontal motion, evaluated on move_tick only:
  - left=1, right=0, xpos>X_MIN: xpos decrements by 1; face_left<=1.
  - right=1, left=0, xpos<X_MAX: xpos increments by 1; face_left<=0.
  - left=1 and right=1: no move; face_left holds.
  - At a bound: xpos holds, but face_left still updates to the pressed direction.
  - Horizontal motion is allowed in every FSM state, including airborne.
- Jump edge: jump_q is the registered copy of jump; jump_rise = jump & ~jump_q.
- Jump tick:
  - jump_cnt counts 0..JUMP_CYCLES-1 and wraps; jump_tick on the terminal count.
  - jump_cnt is cleared to 0 on the IDLE->RISE transition, so the first rise step occurs exactly JUMP_CYCLES cycles after the trigger edge.
- FSM states IDLE, RISE, FALL. A height counter h (6 bits) tracks the rise.
  - IDLE: ypos==GROUND_YPOS, airborne=0. On jump_rise -> RISE with h<=0. A held jump does not retrigger.
  - RISE: on jump_tick, ypos<=ypos-1 and h<=h+1. When h reaches JUMP_HEIGHT-1 and that tick applies -> FALL. Rise duration is JUMP_HEIGHT*JUMP_CYCLES cycles.
  - FALL: on jump_tick, ypos<=ypos+1. The tick that makes ypos==GROUND_YPOS -> IDLE in the same cycle.
  - jump_rise while in RISE or FALL is ignored (no double jump).
- airborne is 1 in RISE and FALL.
- Full jump latency, trigger edge to return to IDLE: 2*JUMP_HEIGHT*JUMP_CYCLES (+1 for the edge register).
- Minimum ypos is GROUND_YPOS-JUMP_HEIGHT (614 with defaults). No arithmetic wrap is possible.
- Reset mid-jump returns the block immediately to the reset values.

Optional Feature:
DONKEY_VAR_JUMP_EN
- Defined: in RISE, if jump==0 (button released) on any cycle, the FSM moves to FALL on the next clock with ypos unchanged. The descent returns to GROUND_YPOS from whatever height was reached, giving a variable jump height of 1..JUMP_HEIGHT pixels.
- Not defined: the jump level is ignored after the trigger edge, and every jump reaches the full JUMP_HEIGHT.

Test Plan:
All scenarios use MOVE_CYCLES=4, JUMP_CYCLES=2, JUMP_HEIGHT=58.
- Reset, idle 20 cycles -> xpos=128, ypos=672, airborne=0, face_left=0 throughout.
- right held 40 cycles -> xpos=138, face_left=0. Then left held 8 cycles -> xpos=136, face_left=1.
- Both left and right held 40 cycles -> xpos unchanged. Force xpos to X_MAX, hold right -> xpos stays 976.
- Single-cycle jump pulse -> airborne rises 1 cycle later. ypos reaches 614 after 116 cycles, returns to 672 after 232 cycles total; airborne=0 afterwards.
- jump held constantly, plus extra pulses mid-air -> exactly one jump completes with no retrigger. Releasing and repressing after landing starts a new jump.
- rst asserted at ypos=640 during RISE -> outputs reach reset values asynchronously, before the next clk edge. With DONKEY_VAR_JUMP_EN, releasing jump after 10 steps -> peak ypos=662, then fall to 672.

Source files
------------

// File: rtl/donkey_move_ctl.sv
// donkey_move_ctl: player-side position controller for the Donkey sprite.
// Converts left/right/jump button levels into registered sprite coordinates.
// Horizontal steps are paced by a free-running move tick; a three-state jump
// FSM (IDLE/RISE/FALL) paced by a jump tick raises and lowers the sprite.
// Optional build macro: DONKEY_VAR_JUMP_EN -- when defined, releasing the jump
// button while rising starts the descent early (variable jump height).
module donkey_move_ctl #(
    parameter int MOVE_CYCLES = 250_000,
    parameter int JUMP_CYCLES = 1_400_000,
    parameter int JUMP_HEIGHT = 58,
    parameter int INIT_XPOS   = 128,
    parameter int GROUND_YPOS = 672,
    parameter int X_MIN       = 0,
    parameter int X_MAX       = 976
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        left,
    input  logic        right,
    input  logic        jump,
    output logic [11:0] xpos,
    output logic [11:0] ypos,
    output logic        airborne,
    output logic        face_left
);

    localparam int MC_W = (MOVE_CYCLES > 1) ? $clog2(MOVE_CYCLES) : 1;
    localparam int JC_W = (JUMP_CYCLES > 1) ? $clog2(JUMP_CYCLES) : 1;

    localparam logic [11:0] X_INIT   = 12'(INIT_XPOS);
    localparam logic [11:0] X_LO     = 12'(X_MIN);
    localparam logic [11:0] X_HI     = 12'(X_MAX);
    localparam logic [11:0] Y_GROUND = 12'(GROUND_YPOS);
    localparam logic [5:0]  H_LAST   = 6'(JUMP_HEIGHT - 1);

`ifdef DONKEY_VAR_JUMP_EN
    localparam bit VAR_JUMP = 1'b1;
`else
    localparam bit VAR_JUMP = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RISE = 2'd1,
        S_FALL = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [MC_W-1:0] r_move_cnt;
    logic [JC_W-1:0] r_jump_cnt;
    logic [11:0]     r_xpos;
    logic [11:0]     r_ypos;
    logic [11:0]     w_ypos_nxt;
    logic [5:0]      r_h;
    logic [5:0]      w_h_nxt;
    logic            r_airborne;
    logic            r_face_left;
    logic            r_jump_q;
    logic            w_move_tick;
    logic            w_jump_tick;
    logic            w_jump_rise;
    logic            w_jump_start;

    assign w_move_tick  = (r_move_cnt == MC_W'(MOVE_CYCLES - 1));
    assign w_jump_tick  = (r_jump_cnt == JC_W'(JUMP_CYCLES - 1));
    assign w_jump_rise  = jump & ~r_jump_q;
    assign w_jump_start = (r_state == S_IDLE) && w_jump_rise;

    assign xpos      = r_xpos;
    assign ypos      = r_ypos;
    assign airborne  = r_airborne;
    assign face_left = r_face_left;

    // Move pacing counter: free-runs in every state, wraps at terminal count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_move_cnt <= '0;
        end else if (w_move_tick) begin
            r_move_cnt <= '0;
        end else begin
            r_move_cnt <= r_move_cnt + MC_W'(1);
        end
    end

    // Jump pacing counter: restarts on a new jump so the first step lands
    // exactly one full period after the trigger edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_jump_cnt <= '0;
        end else if (w_jump_start || w_jump_tick) begin
            r_jump_cnt <= '0;
        end else begin
            r_jump_cnt <= r_jump_cnt + JC_W'(1);
        end
    end

    // Edge register for the jump button.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_jump_q <= 1'b0;
        end else begin
            r_jump_q <= jump;
        end
    end

    // Horizontal motion: one pixel per move tick, clamped to the screen; the
    // facing direction follows the pressed button even when clamped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_xpos      <= X_INIT;
            r_face_left <= 1'b0;
        end else if (w_move_tick) begin
            if (left && !right) begin
                r_face_left <= 1'b1;
                if (r_xpos > X_LO) begin
                    r_xpos <= r_xpos - 12'd1;
                end
            end else if (right && !left) begin
                r_face_left <= 1'b0;
                if (r_xpos < X_HI) begin
                    r_xpos <= r_xpos + 12'd1;
                end
            end
        end
    end

    // Jump FSM state, vertical position and rise height registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_ypos     <= Y_GROUND;
            r_h        <= '0;
            r_airborne <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_ypos     <= w_ypos_nxt;
            r_h        <= w_h_nxt;
            r_airborne <= (w_state_nxt != S_IDLE);
        end
    end

    // Jump FSM next-state: rise JUMP_HEIGHT steps, then fall back to ground.
    // An early release only ends the rise once at least one step was taken,
    // so the descent never starts from ground level.
    always_comb begin
        w_state_nxt = r_state;
        w_ypos_nxt  = r_ypos;
        w_h_nxt     = r_h;
        case (r_state)
            S_IDLE: begin
                if (w_jump_rise) begin
                    w_state_nxt = S_RISE;
                    w_h_nxt     = '0;
                end
            end
            S_RISE: begin
                if (VAR_JUMP && !jump && (r_h != 6'd0)) begin
                    w_state_nxt = S_FALL;
                end else if (w_jump_tick) begin
                    w_ypos_nxt = r_ypos - 12'd1;
                    w_h_nxt    = r_h + 6'd1;
                    if (r_h == H_LAST) begin
                        w_state_nxt = S_FALL;
                    end
                end
            end
            S_FALL: begin
                if (w_jump_tick) begin
                    w_ypos_nxt = r_ypos + 12'd1;
                    if ((r_ypos + 12'd1) == Y_GROUND) begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_ypos_nxt  = Y_GROUND;
                w_h_nxt     = '0;
            end
        endcase
    end

endmodule
